// File: rtl/clkdiv_prog.sv
// clkdiv_prog: multi-channel programmable clock-enable generator.
//
// Each of N_CH channels divides clk by R = max(div_act, 2) and produces a
// one-cycle tick strobe plus a registered square wave. Divisor writes land
// in a per-channel shadow register and are swapped in only at the channel's
// wrap, or immediately by sync, so the period never glitches.
//
// Ports:
//   clk       system clock, all state on the rising edge
//   rst       asynchronous active-high reset
//   ch_en     per-channel count enable
//   sync      restart pulse for all channels (applies pending divisors)
//   cfg_wr    divisor write strobe
//   cfg_ch    target channel of the write (values >= N_CH are ignored)
//   cfg_div   new divisor value
//   cfg_pend  per channel, high while a written divisor awaits application
//   tick      one-cycle strobe per channel period
//   sq        square wave per channel, high for floor(R/2) of every R cycles
//
// Config handshake: cfg_wr is a single-cycle valid with no ready; a write is
// always accepted on the edge where cfg_wr is high. Back-to-back writes to
// the same channel before its swap overwrite each other (last write wins).
module clkdiv_prog #(
  parameter int N_CH      = 4,
  parameter int CNT_WIDTH = 16,
  parameter int DIV_RST   = 2,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      ch_en,
  input  logic                 sync,
  input  logic                 cfg_wr,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [CNT_WIDTH-1:0] cfg_div,
  output logic [N_CH-1:0]      cfg_pend,
  output logic [N_CH-1:0]      tick,
  output logic [N_CH-1:0]      sq
);

  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TWO      = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] DIV_INIT = CNT_WIDTH'(DIV_RST);

  // Divisors 0 and 1 would give a zero- or one-cycle period; both run as 2.
  function automatic logic [CNT_WIDTH-1:0] ratio(input logic [CNT_WIDTH-1:0] d);
    return (d < TWO) ? TWO : d;
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] act_q, act_d;
    logic [CNT_WIDTH-1:0] shd_q, shd_d;
    logic [CNT_WIDTH-1:0] r_cur, r_nxt;
    logic                 pend_q, pend_d;
    logic                 tick_q, tick_d;
    logic                 sq_q, sq_d;
    logic                 wr_hit;
    logic                 wrap;

    // Out-of-range cfg_ch values never match any channel index, so such
    // writes fall through without touching state.
    assign wr_hit = cfg_wr && (cfg_ch == CH_W'(i));
    assign r_cur  = ratio(act_q);
    // >= rather than == keeps the counter bounded even if it ever exceeded R-1.
    assign wrap   = (cnt_q >= (r_cur - ONE));

    always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      shd_d  = wr_hit ? cfg_div : shd_q;
      pend_d = pend_q | wr_hit;
      tick_d = 1'b0;
      if (sync) begin
        // A write in the same cycle as sync is applied by that sync.
        cnt_d  = '0;
        act_d  = wr_hit ? cfg_div : (pend_q ? shd_q : act_q);
        pend_d = 1'b0;
      end else if (ch_en[i]) begin
        if (wrap) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          // The value pending before this edge is swapped in; a write landing
          // on the wrap edge itself waits in the shadow for the next wrap.
          if (pend_q) begin
            act_d = shd_q;
          end
          pend_d = wr_hit;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    end

    // Square wave is evaluated against the ratio in force after this edge,
    // so a divisor swap produces a clean first period at the new rate.
    assign r_nxt = ratio(act_d);
    assign sq_d  = (sync || ch_en[i]) ? (cnt_d < (r_nxt >> 1)) : sq_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        act_q  <= DIV_INIT;
        shd_q  <= DIV_INIT;
        pend_q <= 1'b0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        shd_q  <= shd_d;
        pend_q <= pend_d;
        tick_q <= tick_d;
        sq_q   <= sq_d;
      end
    end

    assign tick[i]     = tick_q;
    assign sq[i]       = sq_q;
    assign cfg_pend[i] = pend_q;
  end

endmodule

// File: tb/tb_clkdiv_prog.sv
module tb_clkdiv_prog;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ch_en = 4'hF;
  logic        sync = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_ch = 2'd0;
  logic [15:0] cfg_div = 16'd0;
  logic [3:0]  cfg_pend, tick, sq;
  logic [2:0]  cfg_pend3, tick3, sq3;

  always #5 clk = ~clk;

  clkdiv_prog #(.N_CH(4), .CNT_WIDTH(16), .DIV_RST(2)) u_dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .sync(sync),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_pend(cfg_pend), .tick(tick), .sq(sq)
  );

  // Three-channel instance: cfg_ch=3 is out of range here.
  clkdiv_prog #(.N_CH(3), .CNT_WIDTH(16), .DIV_RST(2)) u_dut3 (
    .clk(clk), .rst(rst), .ch_en(ch_en[2:0]), .sync(sync),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_pend(cfg_pend3), .tick(tick3), .sq(sq3)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] d);
    cfg_wr  = 1'b1;
    cfg_ch  = ch;
    cfg_div = d;
    cycle();
    cfg_wr  = 1'b0;
  endtask

  // Waits for cfg_pend[ch] to drop; an expired bound is a failed check.
  task automatic wait_apply(input int ch);
    int n;
    logic done;
    done = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      cycle();
      n++;
      if (!cfg_pend[ch]) done = 1'b1;
    end
    chk($sformatf("apply_ch%0d_bounded", ch), done, 1);
  endtask

  // Edges until the next tick on ch; returns -1 if the bound expires.
  task automatic wait_tick(input int ch, output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      cycle();
      n++;
      if (tick[ch]) seen = 1'b1;
    end
    if (!seen) n = -1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [1:0]  ch;
    logic [15:0] div;
    logic [3:0]  tick;
    logic [3:0]  sq;
    logic [3:0]  pend;
  } vec_t;

  function automatic vec_t mkv(input logic wr, input logic [1:0] ch, input logic [15:0] div,
                               input logic [3:0] t, input logic [3:0] s, input logic [3:0] p);
    vec_t v;
    v.wr = wr; v.ch = ch; v.div = div; v.tick = t; v.sq = s; v.pend = p;
    return v;
  endfunction

  vec_t vecs[22];

  // Expected pattern after reset release: R=2 everywhere, edges 2,4,6...
  task automatic check_reset_pattern(input string tag);
    for (int e = 1; e <= 6; e++) begin
      cycle();
      chk($sformatf("%s_tick_e%0d", tag, e), tick, (e % 2 == 0) ? 4'hF : 4'h0);
      chk($sformatf("%s_sq_e%0d", tag, e), sq, (e % 2 == 0) ? 4'hF : 4'h0);
      chk($sformatf("%s_pend_e%0d", tag, e), cfg_pend, 4'h0);
      chk($sformatf("%s_tick3_e%0d", tag, e), tick3, (e % 2 == 0) ? 3'h7 : 3'h0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int n;
    int f0, f1, f2, f3;
    logic p2_seen;

    // Edge k of the table: inputs applied before edge k, outputs checked after.
    vecs[0]  = mkv(0, 0, 0, 4'h0, 4'h0, 4'h0);
    vecs[1]  = mkv(0, 0, 0, 4'hF, 4'hF, 4'h0);
    vecs[2]  = mkv(0, 0, 0, 4'h0, 4'h0, 4'h0);
    vecs[3]  = mkv(0, 0, 0, 4'hF, 4'hF, 4'h0);
    vecs[4]  = mkv(0, 0, 0, 4'h0, 4'h0, 4'h0);
    vecs[5]  = mkv(0, 0, 0, 4'hF, 4'hF, 4'h0);
    vecs[6]  = mkv(0, 0, 0, 4'h0, 4'h0, 4'h0);
    vecs[7]  = mkv(0, 0, 0, 4'hF, 4'hF, 4'h0);
    vecs[8]  = mkv(1, 1, 5, 4'h0, 4'h0, 4'h2);  // ch1 <- 5 mid-period
    vecs[9]  = mkv(0, 0, 0, 4'hF, 4'hF, 4'h0);  // wrap: swap, new period starts
    vecs[10] = mkv(0, 0, 0, 4'h0, 4'h2, 4'h0);
    vecs[11] = mkv(0, 0, 0, 4'hD, 4'hD, 4'h0);
    vecs[12] = mkv(0, 0, 0, 4'h0, 4'h0, 4'h0);
    vecs[13] = mkv(0, 0, 0, 4'hD, 4'hD, 4'h0);
    vecs[14] = mkv(0, 0, 0, 4'h2, 4'h2, 4'h0);  // ch1 tick 5 edges after swap
    vecs[15] = mkv(0, 0, 0, 4'hD, 4'hF, 4'h0);
    vecs[16] = mkv(0, 0, 0, 4'h0, 4'h0, 4'h0);
    vecs[17] = mkv(0, 0, 0, 4'hD, 4'hD, 4'h0);
    vecs[18] = mkv(0, 0, 0, 4'h0, 4'h0, 4'h0);
    vecs[19] = mkv(0, 0, 0, 4'hF, 4'hF, 4'h0);
    vecs[20] = mkv(0, 0, 0, 4'h0, 4'h2, 4'h0);
    vecs[21] = mkv(0, 0, 0, 4'hD, 4'hD, 4'h0);

    // ---- reset defaults ----
    repeat (3) cycle();
    chk("rst_tick", tick, 4'h0);
    chk("rst_sq", sq, 4'h0);
    chk("rst_pend", cfg_pend, 4'h0);
    chk("rst_tick3", tick3, 3'h0);
    rst = 1'b0;

    // ---- table: reset pattern and divisor change on ch1 ----
    for (int i = 0; i < 22; i++) begin
      cfg_wr  = vecs[i].wr;
      cfg_ch  = vecs[i].ch;
      cfg_div = vecs[i].div;
      cycle();
      cfg_wr  = 1'b0;
      chk($sformatf("vec%0d_tick", i + 1), tick, vecs[i].tick);
      chk($sformatf("vec%0d_sq", i + 1), sq, vecs[i].sq);
      chk($sformatf("vec%0d_pend", i + 1), cfg_pend, vecs[i].pend);
      chk($sformatf("vec%0d_tick3", i + 1), tick3, vecs[i].tick[2:0]);
      chk($sformatf("vec%0d_sq3", i + 1), sq3, vecs[i].sq[2:0]);
    end

    // ---- degenerate divisors 0 and 1 on ch0 ----
    cfg_write(2'd0, 16'd0);
    chk("deg0_pend", cfg_pend[0], 1);
    wait_apply(0);
    wait_tick(0, n); chk("deg0_period_a", n, 2);
    wait_tick(0, n); chk("deg0_period_b", n, 2);
    cfg_write(2'd0, 16'd1);
    chk("deg1_pend", cfg_pend[0], 1);
    wait_apply(0);
    wait_tick(0, n); chk("deg1_period_a", n, 2);
    wait_tick(0, n); chk("deg1_period_b", n, 2);

    // ---- cfg_ch out of range for the 3-channel instance ----
    cfg_write(2'd3, 16'd7);
    chk("oor_pend3", cfg_pend3, 3'h0);
    chk("oor_main_pend3", cfg_pend[3], 1);
    begin
      logic a;
      a = tick3[2];
      cycle();
      chk("oor_pend3_later", cfg_pend3, 3'h0);
      chk("oor_ch2_still_r2", a ^ tick3[2], 1);
    end
    wait_apply(3);

    // ---- sync alignment ----
    cfg_write(2'd0, 16'd3);
    wait_apply(0);
    cycle();
    cfg_write(2'd2, 16'd3);
    wait_apply(2);
    if (tick[0]) begin
      // Same phase by chance: slip ch0 by one cycle.
      ch_en[0] = 1'b0;
      cycle();
      ch_en[0] = 1'b1;
    end
    cycle();
    sync = 1'b1;
    cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd6;
    cycle();
    sync = 1'b0; cfg_wr = 1'b0;
    chk("sync_tick", tick, 4'h0);
    chk("sync_sq", sq, 4'hF);
    chk("sync_pend", cfg_pend, 4'h0);
    f0 = 0; f1 = 0; f2 = 0; f3 = 0;
    p2_seen = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      cycle();
      if (tick[0] && f0 == 0) f0 = e;
      if (tick[1] && f1 == 0) f1 = e;
      if (tick[2] && f2 == 0) f2 = e;
      if (tick[3] && f3 == 0) f3 = e;
      if (cfg_pend[2]) p2_seen = 1'b1;
    end
    chk("sync_ch0_first", f0, 3);
    chk("sync_ch1_first", f1, 5);
    chk("sync_ch2_first", f2, 6);
    chk("sync_ch3_first", f3, 7);
    chk("sync_pend2_never", p2_seen, 0);

    // ---- enable hold on ch3 at cnt=1, R=4 ----
    cfg_write(2'd3, 16'd4);
    wait_apply(3);
    cycle();
    chk("hold_sq_cnt1", sq[3], 1);
    ch_en[3] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cycle();
      chk($sformatf("hold_tick_%0d", k), tick[3], 0);
      chk($sformatf("hold_sq_%0d", k), sq[3], 1);
    end
    ch_en[3] = 1'b1;
    wait_tick(3, n);
    chk("hold_resume_edges", n, 3);

    // ---- async reset mid-operation with pending writes ----
    cfg_write(2'd1, 16'd9);
    cfg_write(2'd2, 16'd9);
    chk("arst_pend_before", cfg_pend[2], 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_tick", tick, 4'h0);
    chk("arst_sq", sq, 4'h0);
    chk("arst_pend", cfg_pend, 4'h0);
    chk("arst_pend3", cfg_pend3, 3'h0);
    cycle();
    rst = 1'b0;
    check_reset_pattern("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
